seq_div8: RTL and testbench

SEQ_DIV8 -- requirements
Module: seq_div8

---
 rtl/seq_div8.sv | 160 ++++++++++++++++
 tb/tb_seq_div8.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div8.sv
// seq_div8: 8-bit unsigned sequential divider using the non-restoring
// algorithm. Eight RUN iterations follow the accept edge and one FIX edge
// applies the remainder correction, so done appears 9 edges after accept.
// A zero divisor is answered on the accept edge itself with q=FF, r=dividend.
module seq_div8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e     state_q, state_d;

  // Working registers: A is the 9-bit signed partial remainder, Q collects
  // quotient bits as the dividend shifts out, M holds the divisor.
  logic [8:0] a_q, a_d;
  logic [7:0] q_q, q_d;
  logic [7:0] m_q, m_d;
  logic [2:0] cnt_q, cnt_d;

  // Registered results and status.
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dz_q, dz_d;

  // Shared 9-bit adder: subtract mode inverts M and injects carry-in 1.
  logic [8:0] add_a;
  logic [8:0] add_b;
  logic [8:0] add_sum;
  logic       add_sub;

  // Adder operand selection: RUN feeds the shifted partial remainder and
  // picks add/subtract from the pre-shift sign; FIX adds M back to A.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    add_a   = a_q;
    add_sub = 1'b0;
    if (state_q == ST_RUN) begin
      add_a   = {a_q[7:0], q_q[7]};
      add_sub = ~a_q[8];
    end
    add_b   = add_sub ? ~{1'b0, m_q} : {1'b0, m_q};
    add_sum = add_a + add_b + {8'd0, add_sub};
  end

  // Next-state and datapath control for IDLE / RUN / FIX.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != 8'd0) begin
            a_d     = 9'd0;
            q_d     = dividend;
            m_d     = divisor;
            cnt_d   = 3'd0;
            busy_d  = 1'b1;
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end else begin
            // Division by zero finishes immediately and never goes busy.
            quot_d  = 8'hFF;
            rem_d   = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        a_d   = add_sum;
        q_d   = {q_q[6:0], ~add_sum[8]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        // A negative final partial remainder needs M added back once.
        if (a_q[8]) begin
          a_d = add_sum;
        end
        quot_d  = q_q;
        rem_d   = a_q[8] ? add_sum[7:0] : a_q[7:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      // NOTE: the working registers are cleared too, not only the outputs,
      // so a division cut short by reset leaves no stale operands behind.
      state_q <= ST_IDLE;
      a_q     <= 9'd0;
      q_q     <= 8'd0;
      m_q     <= 8'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8: directed cases, start-while-busy,
// reset mid-run, then random operands against an arithmetic model.
module tb_seq_div8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  int n_pass;
  int n_fail;
  int n_tot;

  seq_div8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after an accept edge. Counts edges until
  // done is seen (bounded) and the samples on which busy was high.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Reference model: plain integer division; b==0 gives FF / dividend.
  task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input int lat, input int bc);
    int exp_q, exp_r, exp_lat;
    if (b == 8'd0) begin
      exp_q   = 255;
      exp_r   = int'(a);
      exp_lat = 0;
    end else begin
      exp_q   = int'(a) / int'(b);
      exp_r   = int'(a) % int'(b);
      exp_lat = 9;
    end
    check({tag, ".latency"},   32'(lat),       32'(exp_lat));
    check({tag, ".busy_cyc"},  32'(bc),        32'(exp_lat));
    check({tag, ".done"},      32'(done),      32'd1);
    check({tag, ".busy_end"},  32'(busy),      32'd0);
    check({tag, ".quotient"},  32'(quotient),  32'(exp_q));
    check({tag, ".remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, ".div_zero"},  32'(div_zero),  32'(b == 8'd0));
  endtask

  // Wait for the result, check it, then check done drops after one cycle.
  task automatic finish_div(input string tag, input logic [7:0] a, input logic [7:0] b);
    int lat, bc;
    wait_done(lat, bc);
    check_result(tag, a, b, lat, bc);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  // One complete division, started at a negedge with the DUT idle.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // Operand changes after the accept edge must not disturb the result.
    dividend = 8'($urandom_range(0, 255));
    divisor  = 8'($urandom_range(0, 255));
    finish_div(tag, a, b);
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    n_pass = 0;
    n_fail = 0;
    n_tot  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (3) @(negedge clk);

    check("reset.quotient",  32'(quotient),  32'd0);
    check("reset.remainder", 32'(remainder), 32'd0);
    check("reset.busy",      32'(busy),      32'd0);
    check("reset.done",      32'(done),      32'd0);
    check("reset.div_zero",  32'(div_zero),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases and boundaries.
    run_div("d100_7",   8'd100, 8'd7);
    run_div("d255_1",   8'd255, 8'd1);
    run_div("d7_9",     8'd7,   8'd9);
    run_div("d255_255", 8'd255, 8'd255);
    run_div("d0_5",     8'd0,   8'd5);
    run_div("d200_0",   8'd200, 8'd0);
    run_div("d10_3",    8'd10,  8'd3);

    // start held high through the run: ignored while busy, accepted in
    // the done cycle.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    finish_div("hold_first", 8'd100, 8'd7);
    start = 1'b0;
    finish_div("hold_second", 8'd50, 8'd5);

    // Reset landing on the 4th RUN edge kills the division.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.quotient",  32'(quotient),  32'd0);
    check("midrst.remainder", 32'(remainder), 32'd0);
    check("midrst.busy",      32'(busy),      32'd0);
    check("midrst.done",      32'(done),      32'd0);
    check("midrst.div_zero",  32'(div_zero),  32'd0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("midrst.no_activity", 32'(seen), 32'd0);
    run_div("d9_2", 8'd9, 8'd2);

    // Zero divisor right after a normal result, then back to normal.
    run_div("d0_0", 8'd0, 8'd0);
    run_div("d1_255", 8'd1, 8'd255);

    // Random operands; roughly one in sixteen divisors forced to zero.
    for (int i = 0; i < 4000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_div("rand", ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
